// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - two-requester arbiter onto one registered RAM port; `define DPRAM_ARB_RR_EN for round-robin ties
module dpram_port_arbiter #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata0,
  input  logic [data_width-1:0] wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [data_width-1:0] rdata0,
  output logic [data_width-1:0] rdata1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [addr_width-1:0] ram_address,
  output logic [data_width-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [data_width-1:0] ram_q
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_ack0, r_ack1;
  logic                  r_rd_pend0, r_rd_pend1;
  logic                  r_rvalid0, r_rvalid1;
  logic [data_width-1:0] r_rdata0_hold, r_rdata1_hold;
  logic [addr_width-1:0] r_ram_address;
  logic [data_width-1:0] r_ram_data;
  logic                  r_ram_wren;
  logic                  w_elig0, w_elig1;
  logic                  w_grant0, w_grant1;
  logic                  w_tie_pick1;

  // A requester is not eligible in the cycle its ack is high; it is updating req then.
  assign w_elig0 = req0 & ~r_ack0;
  assign w_elig1 = req1 & ~r_ack1;

`ifdef DPRAM_ARB_RR_EN
  logic r_rr_ptr;

  // Tie pointer names the requester favoured next; it moves away from whoever was just granted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_grant0) begin
      r_rr_ptr <= 1'b1;
    end else if (w_grant1) begin
      r_rr_ptr <= 1'b0;
    end
  end

  assign w_tie_pick1 = r_rr_ptr;
`else
  assign w_tie_pick1 = 1'b0;
`endif

  // State register for the lock FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant selection and lock transitions; a tie is judged on raw req, so a masked winner yields no grant.
  always_comb begin
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req0 && req1) begin
          if (w_tie_pick1) w_grant1 = w_elig1;
          else             w_grant0 = w_elig0;
        end else begin
          w_grant0 = w_elig0;
          w_grant1 = w_elig1;
        end
        if (w_grant0 && lock0)      w_next_state = ST_LOCK0;
        else if (w_grant1 && lock1) w_next_state = ST_LOCK1;
      end
      ST_LOCK0: begin
        w_grant0 = w_elig0;
        if ((w_grant0 && !lock0) || (!lock0 && !req0)) w_next_state = ST_IDLE;
      end
      ST_LOCK1: begin
        w_grant1 = w_elig1;
        if ((w_grant1 && !lock1) || (!lock1 && !req1)) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Launch the granted access onto the RAM port and track reads through the RAM's one-cycle latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_ram_wren    <= 1'b0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_rd_pend0    <= 1'b0;
      r_rd_pend1    <= 1'b0;
      r_rvalid0     <= 1'b0;
      r_rvalid1     <= 1'b0;
      r_rdata0_hold <= '0;
      r_rdata1_hold <= '0;
    end else begin
      r_ack0     <= w_grant0;
      r_ack1     <= w_grant1;
      r_ram_wren <= (w_grant0 & we0) | (w_grant1 & we1);
      if (w_grant0) begin
        r_ram_address <= addr0;
        r_ram_data    <= wdata0;
      end else if (w_grant1) begin
        r_ram_address <= addr1;
        r_ram_data    <= wdata1;
      end
      r_rd_pend0 <= w_grant0 & ~we0;
      r_rd_pend1 <= w_grant1 & ~we1;
      r_rvalid0  <= r_rd_pend0;
      r_rvalid1  <= r_rd_pend1;
      if (r_rvalid0) r_rdata0_hold <= ram_q;
      if (r_rvalid1) r_rdata1_hold <= ram_q;
    end
  end

  // ram_q is only valid in the rvalid cycle itself, so pass it through then and hold it afterwards.
  assign rdata0      = r_rvalid0 ? ram_q : r_rdata0_hold;
  assign rdata1      = r_rvalid1 ? ram_q : r_rdata1_hold;
  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rvalid0     = r_rvalid0;
  assign rvalid1     = r_rvalid1;
  assign ram_address = r_ram_address;
  assign ram_data    = r_ram_data;
  assign ram_wren    = r_ram_wren;

endmodule
